// File: rtl/dispatch_stage_if.sv
// Bundle between fetch queue, dispatch stage and the execute/issue consumer.
// Output handshake: a transfer happens on the rising edge where out_valid & out_ready are both 1;
// out_valid never drops and out_* never change while out_valid=1 and out_ready=0.
interface dispatch_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] ifq_instr;
  logic [XLEN-1:0] ifq_pc;
  logic            ifq_empty;
  logic            ifq_rd_en;
  logic [XLEN-1:0] jmp_branch_address;
  logic            jmp_branch_valid;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_opclass;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;

  modport master (
    input  ifq_instr, ifq_pc, ifq_empty, out_ready,
    output ifq_rd_en, jmp_branch_address, jmp_branch_valid,
           out_valid, out_instr, out_pc, out_opclass, out_rd, out_rs1, out_rs2, out_imm
  );

  modport slave (
    output ifq_instr, ifq_pc, ifq_empty, out_ready,
    input  ifq_rd_en, jmp_branch_address, jmp_branch_valid,
           out_valid, out_instr, out_pc, out_opclass, out_rd, out_rs1, out_rs2, out_imm
  );
endinterface

// File: rtl/dispatch_stage.sv
// Pops the fetch-queue head, decodes it into a one-deep valid/ready slice and
// redirects fetch on JAL without waiting for execute.
module dispatch_stage #(
  parameter int XLEN         = 32,
  parameter bit JAL_REDIRECT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  dispatch_stage_if.master  bus,
  output logic              dbg_state
);

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

  localparam logic [2:0] CLS_ALU_R  = 3'd0;
  localparam logic [2:0] CLS_ALU_I  = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JAL    = 3'd5;
  localparam logic [2:0] CLS_JALR   = 3'd6;
  localparam logic [2:0] CLS_ILL    = 3'd7;

  state_t          state, next_state;
  logic            pop;
  logic            jal_pop;
  logic [XLEN-1:0] instr;
  logic [2:0]      dec_class;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr = bus.ifq_instr;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Full 7-bit opcode match also rejects any encoding whose low two bits are not 2'b11.
  always_comb begin
    dec_class = CLS_ILL;
    dec_rd    = '0;
    dec_rs1   = '0;
    dec_rs2   = '0;
    dec_imm   = '0;
    case (instr[6:0])
      7'b0110011: begin
        dec_class = CLS_ALU_R;
        dec_rd    = instr[11:7];
        dec_rs1   = instr[19:15];
        dec_rs2   = instr[24:20];
      end
      7'b0010011: begin
        dec_class = CLS_ALU_I;
        dec_rd    = instr[11:7];
        dec_rs1   = instr[19:15];
        dec_imm   = imm_i;
      end
      7'b0110111, 7'b0010111: begin
        dec_class = CLS_ALU_I;
        dec_rd    = instr[11:7];
        dec_imm   = imm_u;
      end
      7'b0000011: begin
        dec_class = CLS_LOAD;
        dec_rd    = instr[11:7];
        dec_rs1   = instr[19:15];
        dec_imm   = imm_i;
      end
      7'b0100011: begin
        dec_class = CLS_STORE;
        dec_rs1   = instr[19:15];
        dec_rs2   = instr[24:20];
        dec_imm   = imm_s;
      end
      7'b1100011: begin
        dec_class = CLS_BRANCH;
        dec_rs1   = instr[19:15];
        dec_rs2   = instr[24:20];
        dec_imm   = imm_b;
      end
      7'b1101111: begin
        dec_class = CLS_JAL;
        dec_rd    = instr[11:7];
        dec_imm   = imm_j;
      end
      7'b1100111: begin
        dec_class = CLS_JALR;
        dec_rd    = instr[11:7];
        dec_rs1   = instr[19:15];
        dec_imm   = imm_i;
      end
      default: ;
    endcase
  end

  // rst_n gates the pop so the strobe is low for the whole reset, not just after the first edge.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    jal_pop    = 1'b0;
    case (state)
      RUN: begin
        pop     = rst_n & ~bus.ifq_empty & (~bus.out_valid | bus.out_ready);
        jal_pop = pop & (dec_class == CLS_JAL) & JAL_REDIRECT;
        if (jal_pop) next_state = REDIRECT;
      end
      REDIRECT: next_state = RUN;
      default:  next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  assign bus.ifq_rd_en        = pop;
  assign bus.jmp_branch_valid = (state == REDIRECT);
  assign dbg_state            = (state == REDIRECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.jmp_branch_address <= '0;
    end else if (jal_pop) begin
      bus.jmp_branch_address <= bus.ifq_pc + dec_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_instr   <= '0;
      bus.out_pc      <= '0;
      bus.out_opclass <= '0;
      bus.out_rd      <= '0;
      bus.out_rs1     <= '0;
      bus.out_rs2     <= '0;
      bus.out_imm     <= '0;
    end else if (pop) begin
      bus.out_valid   <= 1'b1;
      bus.out_instr   <= bus.ifq_instr;
      bus.out_pc      <= bus.ifq_pc;
      bus.out_opclass <= dec_class;
      bus.out_rd      <= dec_rd;
      bus.out_rs1     <= dec_rs1;
      bus.out_rs2     <= dec_rs2;
      bus.out_imm     <= dec_imm;
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dispatch_stage.sv
// Randomised bench for dispatch_stage: fetch-queue driver, a reference decoder, an
// expected-output queue checked by a monitor, and a redirect-pulse model.
module tb_dispatch_stage;

  localparam int EW = 114;  // {instr, pc, opclass, rd, rs1, rs2, imm}

  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic          has_gold;
    logic [EW-1:0] gold;
    logic [31:0]   gold_addr;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;

  dispatch_stage_if #(.XLEN(32)) bus ();

  dispatch_stage #(.XLEN(32), .JAL_REDIRECT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  item_t         fq[$];
  logic [EW-1:0] exp_q[$];
  logic [31:0]   redir_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            in_reset = 1'b1;
  bit            force_ready = 1'b0;
  bit            force_stall = 1'b0;
  bit            allow_bubbles = 1'b0;
  bit            m_valid = 1'b0;
  bit            m_redir = 1'b0;
  logic [6:0]    ops [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h6F, 7'h67};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic [31:0] instr, input logic [31:0] pc,
                                             input logic [2:0] cls, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
    return {instr, pc, cls, rd, rs1, rs2, imm};
  endfunction

  // Reference decode: classify by format, then build the immediate by arithmetic on the fields.
  function automatic logic [EW-1:0] ref_decode(input logic [31:0] instr, input logic [31:0] pc);
    int         sx;
    int         hi;
    int         imm;
    int         fmt;  // 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 none
    logic [2:0] cls;
    logic [4:0] rd, rs1, rs2;
    sx  = int'(instr);
    hi  = sx >>> 31;
    case (instr[6:0])
      7'h33:        begin cls = 3'd0; fmt = 0; end
      7'h13:        begin cls = 3'd1; fmt = 1; end
      7'h37, 7'h17: begin cls = 3'd1; fmt = 4; end
      7'h03:        begin cls = 3'd2; fmt = 1; end
      7'h23:        begin cls = 3'd3; fmt = 2; end
      7'h63:        begin cls = 3'd4; fmt = 3; end
      7'h6F:        begin cls = 3'd5; fmt = 5; end
      7'h67:        begin cls = 3'd6; fmt = 1; end
      default:      begin cls = 3'd7; fmt = 6; end
    endcase
    case (fmt)
      1:       imm = sx >>> 20;
      2:       imm = (sx >>> 25) * 32 + int'(instr[11:7]);
      3:       imm = hi * 4096 + int'(instr[7]) * 2048 + int'(instr[30:25]) * 32 + int'(instr[11:8]) * 2;
      4:       imm = int'({instr[31:12], 12'h000});
      5:       imm = hi * 1048576 + int'(instr[19:12]) * 4096 + int'(instr[20]) * 2048 + int'(instr[30:21]) * 2;
      default: imm = 0;
    endcase
    rd  = (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) ? instr[11:7]  : 5'd0;
    rs1 = (fmt == 0 || fmt == 1 || fmt == 2 || fmt == 3) ? instr[19:15] : 5'd0;
    rs2 = (fmt == 0 || fmt == 2 || fmt == 3)             ? instr[24:20] : 5'd0;
    return pack_exp(instr, pc, cls, rd, rs1, rs2, 32'(imm));
  endfunction

  function automatic item_t mk_gold(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] cls,
                                    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [31:0] imm, input logic [31:0] addr);
    item_t it;
    it.instr     = instr;
    it.pc        = pc;
    it.has_gold  = 1'b1;
    it.gold      = pack_exp(instr, pc, cls, rd, rs1, rs2, imm);
    it.gold_addr = addr;
    return it;
  endfunction

  function automatic item_t mk_rand();
    item_t       it;
    logic [31:0] r;
    int          pick;
    r    = $urandom;
    pick = $urandom_range(0, 11);
    if (pick < 10) r[6:0] = ops[pick];
    it.instr     = r;
    it.pc        = $urandom;
    it.has_gold  = 1'b0;
    it.gold      = '0;
    it.gold_addr = '0;
    return it;
  endfunction

  // Fetch-queue driver: present the head (show-ahead) and a consumer ready on each falling edge.
  initial begin
    bus.ifq_empty = 1'b1;
    bus.ifq_instr = '0;
    bus.ifq_pc    = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (force_ready)      bus.out_ready = 1'b1;
      else if (force_stall) bus.out_ready = 1'b0;
      else                  bus.out_ready = ($urandom_range(0, 99) < 70);
      if (fq.size() > 0 && !(allow_bubbles && $urandom_range(0, 99) < 20)) begin
        bus.ifq_empty = 1'b0;
        bus.ifq_instr = fq[0].instr;
        bus.ifq_pc    = fq[0].pc;
      end else begin
        bus.ifq_empty = 1'b1;
        bus.ifq_instr = $urandom;
        bus.ifq_pc    = $urandom;
      end
    end
  end

  // Monitor: compare handshake behaviour against the model and accepted outputs against exp_q.
  initial forever begin
    @(negedge clk);
    #2;
    if (!in_reset) begin
      chk("ifq_rd_en", bus.ifq_rd_en, !m_redir && !bus.ifq_empty && (!m_valid || bus.out_ready));
      chk("out_valid", bus.out_valid, m_valid);
      chk("jmp_branch_valid", bus.jmp_branch_valid, m_redir);
      if (m_redir && bus.jmp_branch_valid) begin
        if (redir_q.size() == 0) fail_now("redirect_without_expectation");
        else chk("jmp_branch_address", bus.jmp_branch_address, redir_q.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else chk("dispatch_fields",
                 {bus.out_instr, bus.out_pc, bus.out_opclass, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm},
                 exp_q.pop_front());
      end
    end
  end

  // Stimulus side of the scoreboard: each modelled pop pushes its expected dispatch and redirect.
  initial forever begin
    logic [EW-1:0] e;
    bit            exp_rd;
    bit            is_jal;
    @(negedge clk);
    #3;
    if (!in_reset) begin
      exp_rd = !m_redir && !bus.ifq_empty && (!m_valid || bus.out_ready);
      is_jal = 1'b0;
      if (exp_rd && fq.size() > 0) begin
        e = fq[0].has_gold ? fq[0].gold : ref_decode(fq[0].instr, fq[0].pc);
        exp_q.push_back(e);
        if (e[49:47] == 3'd5) begin
          is_jal = 1'b1;
          redir_q.push_back(fq[0].has_gold ? fq[0].gold_addr : fq[0].pc + e[31:0]);
        end
      end
      m_valid = exp_rd ? 1'b1 : (bus.out_ready ? 1'b0 : m_valid);
      m_redir = exp_rd && is_jal;
      if (bus.ifq_rd_en && !bus.ifq_empty && fq.size() > 0) void'(fq.pop_front());
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((fq.size() > 0 || exp_q.size() > 0 || redir_q.size() > 0 || m_valid || m_redir) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) fail_now("drain_timeout");
  endtask

  task automatic clear_model();
    fq.delete();
    exp_q.delete();
    redir_q.delete();
    m_valid = 1'b0;
    m_redir = 1'b0;
  endtask

  initial begin
    #500000;
    fail_now("global_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    bit found;
    // Reset with a non-empty queue: every output must be held at zero.
    fq.push_back(mk_gold(32'h00500093, 32'h0, 3'd1, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0));
    fq.push_back(mk_gold(32'h002081B3, 32'h4, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0));
    fq.push_back(mk_gold(32'h010000EF, 32'h100, 3'd5, 5'd1, 5'd0, 5'd0, 32'd16, 32'h110));
    fq.push_back(mk_gold(32'hFF9FF06F, 32'h4, 3'd5, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 32'hFFFFFFFC));
    fq.push_back(mk_gold(32'h00000000, 32'h8, 3'd7, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0));
    fq.push_back(mk_gold(32'hFE512E23, 32'hC, 3'd3, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC, 32'h0));
    force_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ifq_rd_en", bus.ifq_rd_en, 1'b0);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_jmp_valid", bus.jmp_branch_valid, 1'b0);
    chk("reset_jmp_address", bus.jmp_branch_address, 32'h0);
    chk("reset_out_fields",
        {bus.out_instr, bus.out_pc, bus.out_opclass, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm}, '0);
    chk("reset_state", dbg_state, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;

    // Directed stream: ALU, back-to-back JALs (positive and wrapping), illegal, store.
    wait_drain(100);

    // Back-pressure with a JAL at the head: the pulse must fire while the JAL is stalled.
    @(posedge clk);
    force_ready = 1'b0;
    force_stall = 1'b1;
    fq.push_back(mk_gold(32'h010000EF, 32'h200, 3'd5, 5'd1, 5'd0, 5'd0, 32'd16, 32'h210));
    for (int i = 0; i < 4; i++) fq.push_back(mk_rand());
    repeat (8) @(posedge clk);
    force_stall = 1'b0;
    force_ready = 1'b1;
    wait_drain(100);

    // Random traffic with random back-pressure and queue bubbles.
    @(posedge clk);
    force_ready   = 1'b0;
    allow_bubbles = 1'b1;
    for (int i = 0; i < 300; i++) fq.push_back(mk_rand());
    wait_drain(5000);

    // Asynchronous reset in the middle of a redirect pulse.
    @(posedge clk);
    force_ready   = 1'b1;
    allow_bubbles = 1'b0;
    fq.push_back(mk_gold(32'h010000EF, 32'h300, 3'd5, 5'd1, 5'd0, 5'd0, 32'd16, 32'h310));
    fq.push_back(mk_gold(32'h00500093, 32'h304, 3'd1, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.jmp_branch_valid) found = 1'b1;
    end
    if (!found) fail_now("redirect_pulse_timeout");
    chk("pre_reset_out_valid", bus.out_valid, 1'b1);
    in_reset = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("async_reset_out_valid", bus.out_valid, 1'b0);
    chk("async_reset_jmp_valid", bus.jmp_branch_valid, 1'b0);
    chk("async_reset_ifq_rd_en", bus.ifq_rd_en, 1'b0);
    chk("async_reset_jmp_address", bus.jmp_branch_address, 32'h0);
    chk("async_reset_state", dbg_state, 1'b0);
    clear_model();
    fq.push_back(mk_gold(32'h002081B3, 32'h400, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    wait_drain(100);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
